uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
Parametrised full-duplex UART core. It generalises the fixed 8-bit link of the current controller to a configurable data width, parity mode, stop-bit count and oversampling ratio. It contains its own reset synchroniser, baud tick generator, an RX deframer with parity and framing checking, and a TX framer with per-frame error injection. It sits between the board UART pins and the protocol FSM, replacing the existing UART and error-generator pair.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DATA_W, 8, data bits per frame; legal range 5..9
PARITY, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
OVERSAMPLE, 16, baud ticks per bit; even, minimum 4

Ports:
CLK  in  1  system clock
SYS_NRST  in  1  asynchronous active-low reset
RXD  in  1  serial input, asynchronous to CLK
TXD  out  1  serial output
TX_DATA  in  DATA_W  word to transmit
TX_VALID  in  1  transmit request
TX_READY  out  1  core can accept a word
INJ_PAR_ERR  in  1  invert the parity bit of the frame being accepted
INJ_FRM_ERR  in  1  drive the first stop bit of the frame being accepted to 0
RX_DATA  out  DATA_W  last received word
RX_VALID  out  1  one-cycle pulse per received frame
RX_PAR_ERR  out  1  parity mismatch on the frame flagged by RX_VALID
RX_FRM_ERR  out  1  first stop bit sampled low on the frame flagged by RX_VALID

Behaviour:
- Reset: clock CLK, reset SYS_NRST, asynchronous, active-low. Internal reset asserts asynchronously and deasserts on the 2nd CLK rising edge after SYS_NRST rises. This uses a 2-flop synchroniser; all other logic resets from the internal reset.
- Reset values: TXD=1, TX_READY=0, RX_DATA=0, RX_VALID=0, RX_PAR_ERR=0, RX_FRM_ERR=0. TX_READY goes to 1 on the first cycle after internal reset releases.
- Baud tick: DIV = max(1, floor(CLK_HZ/(BAUD*OVERSAMPLE))). A free-running counter emits a 1-CLK tick every DIV cycles. It restarts only on reset.
- RXD passes through a 2-flop synchroniser, giving 2 CLK of input latency. It is held high during reset.
- RX FSM:
  - IDLE: wait for synced RXD=0, then go to START.
  - START: count OVERSAMPLE/2 ticks, then resample. If RXD=0, go to DATA; otherwise the low pulse is a glitch and the FSM returns to IDLE with no output.
  - DATA: sample every OVERSAMPLE ticks, shifting DATA_W bits LSB first.
  - PAR: present only when PARITY≠0; sample one bit.
  - STOP: sample one bit. Only the first stop bit is checked, even when STOP_BITS=2.
- RX output: on the CLK after the stop sample, RX_VALID=1 for exactly one cycle. RX_DATA, RX_PAR_ERR and RX_FRM_ERR update on that same cycle and hold until the next frame. Frames with errors are still delivered.
- RX break: if the stop sample is 0, the FSM enters WAIT_HI after RX_VALID and returns to IDLE only after synced RXD=1.
- TX handshake:
  - Accept on the CLK edge where TX_VALID & TX_READY are both high. TX_DATA, INJ_PAR_ERR and INJ_FRM_ERR are latched on that edge.
  - TX_READY=0 from the next cycle until the last stop bit completes. It returns to 1 on the following CLK.
  - TX_VALID while TX_READY=0 is ignored; no queueing.
- TX frame: start 0, then DATA_W data bits LSB first, then parity (if enabled), then STOP_BITS bits of 1. Each bit lasts OVERSAMPLE ticks. TXD changes on tick boundaries; the start bit begins on the first tick after accept.
- Parity: even mode sends XOR of the data bits; odd mode sends its inverse. INJ_PAR_ERR inverts the transmitted parity bit and has no effect when PARITY=0.
- Framing injection: INJ_FRM_ERR drives the first stop bit to 0. A second stop bit, if present, remains 1. TXD returns to 1 afterwards.
- RX and TX are fully independent; simultaneous RX completion and TX accept are both honoured.
- Reset mid-frame: both FSMs abort to IDLE and TXD goes high immediately (asynchronously). No RX_VALID is emitted for the partial frame.

Test Plan:
- Bench parameters are CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16 (DIV=1, 16 CLK/bit), TXD looped back to RXD.
- 8E1: send TX_DATA=0xA5 -> TXD bit sequence 0,1,0,1,0,0,1,0,1,0,1; RX_VALID pulses once with RX_DATA=0xA5, RX_PAR_ERR=0, RX_FRM_ERR=0; TX_READY low for 176 CLK.
- 8E1 with INJ_PAR_ERR=1 at accept, TX_DATA=0x3C -> RX_DATA=0x3C, RX_PAR_ERR=1, RX_FRM_ERR=0. Next frame 0x3C without injection -> both flags 0.
- 8E1 with INJ_FRM_ERR=1, TX_DATA=0xFF -> RX_FRM_ERR=1, RX_DATA=0xFF. RX waits for line high, then accepts a following 0x00 correctly.
- Glitch: drive RXD low for 4 CLK then high (loopback off) -> no RX_VALID; a following valid 0x55 frame is received.
- DATA_W=9, PARITY=2, STOP_BITS=2: send 0x1A3 -> parity bit 0 (five ones, odd), two stop bits, frame 208 CLK; RX_DATA=0x1A3.
- Assert SYS_NRST=0 during data bit 3 of a TX frame -> TXD=1 and TX_READY=0 immediately, no RX_VALID; TX_READY=1 on the 3rd CLK after release.

Source files
------------

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: reset sync, baud ticks, RX deframer with checks, TX framer with error injection.
// Latency: RXD is synchronised in 2 CLK; RX_VALID follows the stop-bit sample by 1 CLK; TX start bit begins on the first tick after accept.
// Backpressure: TX_READY stays low for the whole frame and requests made meanwhile are dropped; RX has no backpressure and delivers every frame.
module uart_core_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic              CLK,
  input  logic              SYS_NRST,
  input  logic              RXD,
  output logic              TXD,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic              INJ_PAR_ERR,
  input  logic              INJ_FRM_ERR,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              RX_PAR_ERR,
  output logic              RX_FRM_ERR
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int PAR_EN  = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_W = 1 + DATA_W + PAR_EN + STOP_BITS;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int RXB_W   = $clog2(DATA_W);

  // ---------------------------------------------------------------- reset
  logic [1:0] rst_sync;
  logic       rst_n;

  // Internal reset asserts with SYS_NRST and releases on the 2nd CLK edge after it rises
  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------- baud tick
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // Free-running divider: one-cycle tick every DIV clocks
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- receiver
  logic [1:0] rxd_sync;
  logic       rxd_s;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) rxd_sync <= 2'b11;
    else        rxd_sync <= {rxd_sync[0], RXD};
  end

  assign rxd_s = rxd_sync[1];

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA_S, RX_PAR, RX_STOP, RX_WAIT_HI
  } rx_state_t;

  rx_state_t         rx_state;
  logic [OS_W-1:0]   rx_tcnt;
  logic [RXB_W-1:0]  rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_par_bit;
  logic              rx_par_err;

  // Parity check over the assembled word and the received parity bit
  assign rx_par_err = (PARITY == 0) ? 1'b0 :
                      (PARITY == 1) ? (^rx_shift ^ rx_par_bit) :
                                      ~(^rx_shift ^ rx_par_bit);

  // RX deframer: mid-bit sampling from the start edge, outputs registered on the stop sample
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_tcnt    <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      RX_PAR_ERR <= 1'b0;
      RX_FRM_ERR <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rxd_s) begin
            rx_state <= RX_START;
            rx_tcnt  <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tcnt == OS_W'(OVERSAMPLE / 2 - 1)) begin
              rx_tcnt  <= '0;
              rx_bit   <= '0;
              rx_state <= rxd_s ? RX_IDLE : RX_DATA_S;
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
        end
        RX_DATA_S: begin
          if (tick) begin
            if (rx_tcnt == OS_W'(OVERSAMPLE - 1)) begin
              rx_tcnt  <= '0;
              rx_shift <= {rxd_s, rx_shift[DATA_W-1:1]};
              if (rx_bit == RXB_W'(DATA_W - 1)) rx_state <= (PARITY != 0) ? RX_PAR : RX_STOP;
              else                              rx_bit   <= rx_bit + 1'b1;
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
        end
        RX_PAR: begin
          if (tick) begin
            if (rx_tcnt == OS_W'(OVERSAMPLE - 1)) begin
              rx_tcnt    <= '0;
              rx_par_bit <= rxd_s;
              rx_state   <= RX_STOP;
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_tcnt == OS_W'(OVERSAMPLE - 1)) begin
              rx_tcnt    <= '0;
              RX_VALID   <= 1'b1;
              RX_DATA    <= rx_shift;
              RX_PAR_ERR <= rx_par_err;
              RX_FRM_ERR <= ~rxd_s;
              // A low stop bit may be a break: wait for the line to recover
              rx_state   <= rxd_s ? RX_IDLE : RX_WAIT_HI;
            end else begin
              rx_tcnt <= rx_tcnt + 1'b1;
            end
          end
        end
        RX_WAIT_HI: begin
          if (rxd_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- transmitter
  logic               tx_par;
  logic [FRAME_W-1:0] tx_frame_in;

  assign tx_par = ((PARITY == 2) ? ~(^TX_DATA) : (^TX_DATA)) ^ INJ_PAR_ERR;

  // Whole frame assembled at accept time, LSB goes on the line first
  always_comb begin
    tx_frame_in              = '1;
    tx_frame_in[0]           = 1'b0;
    tx_frame_in[DATA_W:1]    = TX_DATA;
    if (PARITY != 0) tx_frame_in[DATA_W+1] = tx_par;
    if (INJ_FRM_ERR) tx_frame_in[DATA_W+1+PAR_EN] = 1'b0;
  end

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND} tx_state_t;

  tx_state_t          tx_state;
  logic [FRAME_W-1:0] tx_shift;
  logic [OS_W-1:0]    tx_tcnt;
  logic [BIT_W-1:0]   tx_bit;

  // TX framer: one bit per OVERSAMPLE ticks; READY reopens on the final tick of the last stop bit
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      TXD      <= 1'b1;
      TX_READY <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          TX_READY <= 1'b1;
          TXD      <= 1'b1;
          if (TX_VALID && TX_READY) begin
            tx_shift <= tx_frame_in;
            TX_READY <= 1'b0;
            tx_state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tick) begin
            TXD      <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[FRAME_W-1:1]};
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tick) begin
            if (tx_bit == BIT_W'(FRAME_W - 1) && tx_tcnt == OS_W'(OVERSAMPLE - 2)) begin
              TXD      <= 1'b1;
              TX_READY <= 1'b1;
              tx_state <= TX_IDLE;
            end else if (tx_tcnt == OS_W'(OVERSAMPLE - 1)) begin
              TXD      <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[FRAME_W-1:1]};
              tx_tcnt  <= '0;
              tx_bit   <= tx_bit + 1'b1;
            end else begin
              tx_tcnt <= tx_tcnt + 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Loopback bench for uart_core_param: 8E1 instance (a) and 9-bit odd-parity 2-stop instance (b).
// 16 CLK per bit; TXD bits are checked mid-bit against a frame model built from the data word.
// RX results are collected by a pulse monitor and compared per frame.
module tb_uart_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: 8 data bits, even parity, 1 stop
  logic       nrst_a, lb_a, rxd_drv, a_rxd, a_txd, a_tx_valid, a_tx_ready, a_injp, a_injf;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_rx_valid, a_rx_perr, a_rx_ferr;
  // instance b: 9 data bits, odd parity, 2 stop
  logic       nrst_b, b_txd, b_tx_valid, b_tx_ready, b_injp, b_injf;
  logic [8:0] b_tx_data, b_rx_data;
  logic       b_rx_valid, b_rx_perr, b_rx_ferr;

  assign a_rxd = lb_a ? a_txd : rxd_drv;

  uart_core_param #(.CLK_HZ(1600000), .BAUD(100000), .DATA_W(8), .PARITY(1),
                    .STOP_BITS(1), .OVERSAMPLE(16)) u_a (
    .CLK(clk), .SYS_NRST(nrst_a), .RXD(a_rxd), .TXD(a_txd),
    .TX_DATA(a_tx_data), .TX_VALID(a_tx_valid), .TX_READY(a_tx_ready),
    .INJ_PAR_ERR(a_injp), .INJ_FRM_ERR(a_injf),
    .RX_DATA(a_rx_data), .RX_VALID(a_rx_valid), .RX_PAR_ERR(a_rx_perr), .RX_FRM_ERR(a_rx_ferr));

  uart_core_param #(.CLK_HZ(1600000), .BAUD(100000), .DATA_W(9), .PARITY(2),
                    .STOP_BITS(2), .OVERSAMPLE(16)) u_b (
    .CLK(clk), .SYS_NRST(nrst_b), .RXD(b_txd), .TXD(b_txd),
    .TX_DATA(b_tx_data), .TX_VALID(b_tx_valid), .TX_READY(b_tx_ready),
    .INJ_PAR_ERR(b_injp), .INJ_FRM_ERR(b_injf),
    .RX_DATA(b_rx_data), .RX_VALID(b_rx_valid), .RX_PAR_ERR(b_rx_perr), .RX_FRM_ERR(b_rx_ferr));

  int vectors = 0;
  int miscompares = 0;
  int a_rx_cnt = 0;
  int b_rx_cnt = 0;

  // RX pulse monitor: counts cycles with RX_VALID high
  always @(negedge clk) begin
    if (a_rx_valid) a_rx_cnt++;
    if (b_rx_valid) b_rx_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [8:0] d, input logic p, input logic f);
    if (sel) begin
      b_tx_valid = v; b_tx_data = d; b_injp = p; b_injf = f;
    end else begin
      a_tx_valid = v; a_tx_data = d[7:0]; a_injp = p; a_injf = f;
    end
  endtask

  // Send one frame on the selected instance and check line bits, READY window and the looped-back result
  task automatic send(input bit sel, input logic [8:0] d, input bit injp, input bit injf, input string tag);
    int dw, nb, ones, rdy_low, cnt0, tot, ncyc;
    bit parb;
    bit expb[16];
    bit txh[240];
    bit rdh[240];
    dw = sel ? 9 : 8;
    nb = 1 + dw + 1 + (sel ? 2 : 1);
    tot = nb * 16 + 24;
    ones = 0;
    for (int i = 0; i < dw; i++) ones += int'(d[i]);
    parb = sel ? ((ones % 2) == 0) : ((ones % 2) == 1);
    parb = parb ^ injp;
    expb[0] = 1'b0;
    for (int i = 0; i < dw; i++) expb[1+i] = d[i];
    expb[dw+1] = parb;
    expb[dw+2] = ~injf;
    if (sel) expb[dw+3] = 1'b1;

    @(negedge clk);
    ncyc = 0;
    while (!(sel ? b_tx_ready : a_tx_ready) && ncyc < 400) begin
      @(negedge clk);
      ncyc++;
    end
    chk($sformatf("%s_ready_before", tag), {31'd0, (sel ? b_tx_ready : a_tx_ready)}, 32'd1);
    cnt0 = sel ? b_rx_cnt : a_rx_cnt;
    drive(sel, 1'b1, d, injp, injf);
    @(posedge clk);
    for (int c = 0; c < tot; c++) begin
      @(negedge clk);
      txh[c] = sel ? b_txd : a_txd;
      rdh[c] = sel ? b_tx_ready : a_tx_ready;
      if (c == 0)  drive(sel, 1'b0, d, 1'b0, 1'b0);
      if (c == 20) drive(sel, 1'b1, ~d, 1'b1, 1'b1);
      if (c == 40) drive(sel, 1'b0, d, 1'b0, 1'b0);
    end
    for (int k = 0; k < nb; k++)
      chk($sformatf("%s_txd_bit%0d", tag, k), {31'd0, txh[9+16*k]}, {31'd0, expb[k]});
    rdy_low = 0;
    while (rdy_low < tot && !rdh[rdy_low]) rdy_low++;
    chk($sformatf("%s_ready_low_cycles", tag), rdy_low, nb * 16);
    chk($sformatf("%s_rx_pulses", tag), (sel ? b_rx_cnt : a_rx_cnt) - cnt0, 1);
    chk($sformatf("%s_rx_data", tag), sel ? {23'd0, b_rx_data} : {24'd0, a_rx_data}, {23'd0, d});
    chk($sformatf("%s_rx_par_err", tag), {31'd0, (sel ? b_rx_perr : a_rx_perr)}, {31'd0, injp});
    chk($sformatf("%s_rx_frm_err", tag), {31'd0, (sel ? b_rx_ferr : a_rx_ferr)}, {31'd0, injf});
  endtask

  initial begin
    int cnt0;
    logic [8:0] rd;
    nrst_a = 1'b0; nrst_b = 1'b0; lb_a = 1'b1; rxd_drv = 1'b1;
    drive(1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 9'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("reset_txd", {31'd0, a_txd}, 32'd1);
    chk("reset_tx_ready", {31'd0, a_tx_ready}, 32'd0);
    chk("reset_rx_data", {24'd0, a_rx_data}, 32'd0);
    chk("reset_rx_valid", {31'd0, a_rx_valid}, 32'd0);
    chk("reset_rx_flags", {30'd0, a_rx_perr, a_rx_ferr}, 32'd0);
    chk("reset_b_txd", {31'd0, b_txd}, 32'd1);
    nrst_a = 1'b1; nrst_b = 1'b1;
    @(negedge clk); chk("release_ready_e1", {31'd0, a_tx_ready}, 32'd0);
    @(negedge clk); chk("release_ready_e2", {31'd0, a_tx_ready}, 32'd0);
    @(negedge clk); chk("release_ready_e3", {31'd0, a_tx_ready}, 32'd1);

    // directed 8E1 frames
    send(1'b0, 9'h0A5, 1'b0, 1'b0, "a5");
    send(1'b0, 9'h03C, 1'b1, 1'b0, "3c_parinj");
    send(1'b0, 9'h03C, 1'b0, 1'b0, "3c_clean");
    send(1'b0, 9'h0FF, 1'b0, 1'b1, "ff_frminj");
    send(1'b0, 9'h000, 1'b0, 1'b0, "00_after_break");

    // short low glitch on RXD with loopback off
    @(negedge clk);
    cnt0 = a_rx_cnt;
    lb_a = 1'b0; rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_rx", a_rx_cnt - cnt0, 0);
    lb_a = 1'b1;
    send(1'b0, 9'h055, 1'b0, 1'b0, "55_after_glitch");

    // 9-bit odd parity, two stop bits
    send(1'b1, 9'h1A3, 1'b0, 1'b0, "b_1a3");

    // randomized frames on both instances
    for (int r = 0; r < 6; r++) begin
      rd = 9'($urandom_range(0, 255));
      send(1'b0, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $sformatf("rnd_a%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      rd = 9'($urandom_range(0, 511));
      send(1'b1, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $sformatf("rnd_b%0d", r));
    end

    // reset during data bit 3 of a TX frame
    @(negedge clk);
    cnt0 = a_rx_cnt;
    drive(1'b0, 1'b1, 9'h000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    repeat (70) @(negedge clk);
    chk("midreset_txd_before", {31'd0, a_txd}, 32'd0);
    #2 nrst_a = 1'b0;
    #1;
    chk("midreset_txd_async", {31'd0, a_txd}, 32'd1);
    chk("midreset_ready_async", {31'd0, a_tx_ready}, 32'd0);
    repeat (5) @(negedge clk);
    nrst_a = 1'b1;
    @(negedge clk); chk("midreset_ready_e1", {31'd0, a_tx_ready}, 32'd0);
    @(negedge clk); chk("midreset_ready_e2", {31'd0, a_tx_ready}, 32'd0);
    @(negedge clk); chk("midreset_ready_e3", {31'd0, a_tx_ready}, 32'd1);
    repeat (200) @(negedge clk);
    chk("midreset_no_rx", a_rx_cnt - cnt0, 0);
    send(1'b0, 9'h0C3, 1'b0, 1'b0, "c3_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
